// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file geometry and scoreboard defaults used by reg_scoreboard and its counters.
package reg_scoreboard_pkg;

  localparam int REG_ADDR_LEN    = 4;
  localparam int REG_NUM         = 16;
  localparam int SB_MAX_INFLIGHT = 3;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down with an underflow indication.
module sb_counter #(
  parameter int CNT_W = 3,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec_req,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             dec_taken,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             dec_taken_s;

  // Next count: a write-back only decrements a pending counter; inc+dec cancel out.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    dec_taken_s = dec_req && (cnt_r != {CNT_W{1'b0}});
    if (inc && !dec_taken_s) begin
      if (cnt_r != CNT_W'(MAX)) begin
        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (!inc && dec_taken_s) begin
      cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt       = cnt_r;
  assign cnt_nxt   = cnt_nxt_s;
  assign dec_taken = dec_taken_s;
  assign underflow = dec_req && (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending write-backs and stalls ID on RAW or saturation hazards.
// Optional write-back bypass (fwd1/fwd2 outputs) enabled by defining SCOREBOARD_FWD_EN.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int CNT_W        = 3,
  parameter int TOT_W        = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic                    issue_we,
  input  logic [REG_ADDR_LEN-1:0] issue_waddr,
  input  logic                    issue_use1,
  input  logic [REG_ADDR_LEN-1:0] issue_raddr1,
  input  logic                    issue_use2,
  input  logic [REG_ADDR_LEN-1:0] issue_raddr2,
  input  logic                    wb_valid,
  input  logic [REG_ADDR_LEN-1:0] wb_waddr,
  output logic                    stall,
  output logic                    issue_fire,
`ifdef SCOREBOARD_FWD_EN
  output logic                    fwd1,
  output logic                    fwd2,
`endif
  output logic [REG_NUM-1:0]      busy_vec,
  output logic [TOT_W-1:0]        inflight,
  output logic                    err_underflow
);

  logic [CNT_W-1:0]   cnt_s     [REG_NUM];
  logic [CNT_W-1:0]   cnt_nxt_s [REG_NUM];
  logic [REG_NUM-1:0] inc_s;
  logic [REG_NUM-1:0] wbsel_s;
  logic [REG_NUM-1:0] dec_s;
  logic [REG_NUM-1:0] udf_s;
  logic [REG_NUM-1:0] busy_nxt_s;
  logic               haz1_s;
  logic               haz2_s;
  logic               sat_s;
  logic               fwd1_s;
  logic               fwd2_s;
  logic               stall_s;
  logic [REG_NUM-1:0] busy_r;
  logic [TOT_W-1:0]   inflight_r;
  logic               err_r;

  assign cnt_s[0]     = {CNT_W{1'b0}};
  assign cnt_nxt_s[0] = {CNT_W{1'b0}};
  assign dec_s[0]     = 1'b0;
  assign udf_s[0]     = 1'b0;

  // Hazard detection from current counters; register 0 is never pending.
  always_comb begin
    fwd1_s = 1'b0;
    fwd2_s = 1'b0;
`ifdef SCOREBOARD_FWD_EN
    fwd1_s = issue_valid && issue_use1 && (issue_raddr1 != {REG_ADDR_LEN{1'b0}}) &&
             wb_valid && (wb_waddr == issue_raddr1) &&
             (cnt_s[issue_raddr1] == {{(CNT_W-1){1'b0}}, 1'b1});
    fwd2_s = issue_valid && issue_use2 && (issue_raddr2 != {REG_ADDR_LEN{1'b0}}) &&
             wb_valid && (wb_waddr == issue_raddr2) &&
             (cnt_s[issue_raddr2] == {{(CNT_W-1){1'b0}}, 1'b1});
`endif
    haz1_s  = issue_use1 && (issue_raddr1 != {REG_ADDR_LEN{1'b0}}) &&
              (cnt_s[issue_raddr1] != {CNT_W{1'b0}}) && !fwd1_s;
    haz2_s  = issue_use2 && (issue_raddr2 != {REG_ADDR_LEN{1'b0}}) &&
              (cnt_s[issue_raddr2] != {CNT_W{1'b0}}) && !fwd2_s;
    sat_s   = issue_we && (issue_waddr != {REG_ADDR_LEN{1'b0}}) &&
              (cnt_s[issue_waddr] == CNT_W'(MAX_INFLIGHT));
    stall_s = issue_valid && (haz1_s || haz2_s || sat_s);
  end

  assign stall      = stall_s;
  assign issue_fire = issue_valid && !stall_s;
`ifdef SCOREBOARD_FWD_EN
  assign fwd1 = fwd1_s;
  assign fwd2 = fwd2_s;
`endif

  // Per-register increment and write-back select decode.
  always_comb begin
    inc_s   = {REG_NUM{1'b0}};
    wbsel_s = {REG_NUM{1'b0}};
    for (int r = 1; r < REG_NUM; r++) begin
      inc_s[r]   = issue_valid && !stall_s && issue_we && (issue_waddr == REG_ADDR_LEN'(r));
      wbsel_s[r] = wb_valid && (wb_waddr == REG_ADDR_LEN'(r));
    end
  end

  genvar g;
  generate
    for (g = 1; g < REG_NUM; g++) begin : g_cnt
      sb_counter #(
        .CNT_W (CNT_W),
        .MAX   (MAX_INFLIGHT)
      ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc_s[g]),
        .dec_req   (wbsel_s[g]),
        .cnt       (cnt_s[g]),
        .cnt_nxt   (cnt_nxt_s[g]),
        .dec_taken (dec_s[g]),
        .underflow (udf_s[g])
      );
    end
  endgenerate

  // Busy vector follows the counters' next values so it lines up with them.
  always_comb begin
    busy_nxt_s = {REG_NUM{1'b0}};
    for (int r = 0; r < REG_NUM; r++) begin
      busy_nxt_s[r] = (cnt_nxt_s[r] != {CNT_W{1'b0}});
    end
  end

  // Registered summary outputs; at most one increment and one decrement per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r     <= {REG_NUM{1'b0}};
      inflight_r <= {TOT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      inflight_r <= inflight_r + {{(TOT_W-1){1'b0}}, (|inc_s)}
                               - {{(TOT_W-1){1'b0}}, (|dec_s)};
      err_r      <= err_r || (|udf_s);
    end
  end

  assign busy_vec      = busy_r;
  assign inflight      = inflight_r;
  assign err_underflow = err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic vs a counter-array model.
module tb_reg_scoreboard;

  localparam int MAXI = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_we, issue_use1, issue_use2, wb_valid;
  logic [3:0]  issue_waddr, issue_raddr1, issue_raddr2, wb_waddr;
  logic        stall, issue_fire;
  logic [15:0] busy_vec;
  logic [5:0]  inflight;
  logic        err_underflow;
`ifdef SCOREBOARD_FWD_EN
  logic        fwd1, fwd2;
`endif

  int errors = 0;
  int checks = 0;

  int cnt_m [16];
  bit err_m;
  bit obs_stall, obs_fire;
`ifdef SCOREBOARD_FWD_EN
  bit obs_fwd1;
`endif

  reg_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_we      (issue_we),
    .issue_waddr   (issue_waddr),
    .issue_use1    (issue_use1),
    .issue_raddr1  (issue_raddr1),
    .issue_use2    (issue_use2),
    .issue_raddr2  (issue_raddr2),
    .wb_valid      (wb_valid),
    .wb_waddr      (wb_waddr),
    .stall         (stall),
    .issue_fire    (issue_fire),
`ifdef SCOREBOARD_FWD_EN
    .fwd1          (fwd1),
    .fwd2          (fwd2),
`endif
    .busy_vec      (busy_vec),
    .inflight      (inflight),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, update model at posedge, check state.
  task automatic cycle(input bit rn, input bit v, input bit we, input int wa,
                       input bit u1, input int r1, input bit u2, input int r2,
                       input bit wv, input int wba);
    bit h1, h2, sat, f1, f2, es, fire;
    int sum;
    logic [15:0] bv;
    @(negedge clk);
    rst_n = rn; issue_valid = v; issue_we = we; issue_waddr = wa[3:0];
    issue_use1 = u1; issue_raddr1 = r1[3:0]; issue_use2 = u2; issue_raddr2 = r2[3:0];
    wb_valid = wv; wb_waddr = wba[3:0];
    #1;
    f1 = 1'b0; f2 = 1'b0;
`ifdef SCOREBOARD_FWD_EN
    f1 = v && u1 && r1 != 0 && wv && wba == r1 && cnt_m[r1] == 1;
    f2 = v && u2 && r2 != 0 && wv && wba == r2 && cnt_m[r2] == 1;
    chk("fwd1", fwd1, f1);
    chk("fwd2", fwd2, f2);
    obs_fwd1 = fwd1;
`endif
    h1   = u1 && r1 != 0 && cnt_m[r1] != 0 && !f1;
    h2   = u2 && r2 != 0 && cnt_m[r2] != 0 && !f2;
    sat  = we && wa != 0 && cnt_m[wa] == MAXI;
    es   = v && (h1 || h2 || sat);
    fire = v && !es;
    chk("stall", stall, es);
    chk("issue_fire", issue_fire, fire);
    obs_stall = stall;
    obs_fire  = issue_fire;
    @(posedge clk);
    if (!rn) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      err_m = 1'b0;
    end else begin
      if (wv && wba != 0) begin
        if (cnt_m[wba] == 0) err_m = 1'b1;
        else cnt_m[wba]--;
      end
      if (fire && we && wa != 0) cnt_m[wa]++;
    end
    #1;
    sum = 0;
    bv  = 16'h0000;
    foreach (cnt_m[i]) begin
      sum += cnt_m[i];
      bv[i] = (cnt_m[i] != 0);
    end
    chk("busy_vec", busy_vec, bv);
    chk("inflight", inflight, sum);
    chk("err_underflow", err_underflow, err_m);
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (cnt_m[i]) cnt_m[i] = 0;
    err_m = 1'b0;
    rst_n = 1'b0; issue_valid = 1'b0; issue_we = 1'b0; issue_waddr = 4'd0;
    issue_use1 = 1'b0; issue_raddr1 = 4'd0; issue_use2 = 1'b0; issue_raddr2 = 4'd0;
    wb_valid = 1'b0; wb_waddr = 4'd0;

    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset busy_vec", busy_vec, 16'h0000);
    chk("reset inflight", inflight, 0);
    chk("reset err", err_underflow, 0);

    // Issue to r5.
    cycle(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    chk("issue5 fire", obs_fire, 1);
    chk("issue5 busy", busy_vec, 16'h0020);
    chk("issue5 inflight", inflight, 1);

    // Dependent read of r5.
    cycle(1, 1, 0, 0, 1, 5, 0, 0, 0, 0);
    chk("raw stall", obs_stall, 1);
    cycle(1, 1, 0, 0, 1, 5, 0, 0, 1, 5);
`ifdef SCOREBOARD_FWD_EN
    chk("wb cycle stall fwd", obs_stall, 0);
    chk("wb cycle fwd1", obs_fwd1, 1);
`else
    chk("wb cycle stall", obs_stall, 1);
`endif
    cycle(1, 1, 0, 0, 1, 5, 0, 0, 0, 0);
    chk("after wb stall", obs_stall, 0);
    chk("after wb busy", busy_vec, 16'h0000);

    // Saturation on r7.
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
    chk("sat inflight", inflight, 3);
    cycle(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
    chk("sat stall", obs_stall, 1);
    chk("sat inflight hold", inflight, 3);
    cycle(1, 1, 1, 7, 0, 0, 0, 0, 1, 7);
    chk("sat stall in wb cycle", obs_stall, 1);
    chk("sat after wb inflight", inflight, 2);
    cycle(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
    chk("sat fourth fires", obs_fire, 1);
    chk("sat refill inflight", inflight, 3);

    // Simultaneous issue and write-back on r9.
    cycle(1, 1, 1, 9, 0, 0, 0, 0, 0, 0);
    chk("r9 inflight", inflight, 4);
    cycle(1, 1, 1, 9, 0, 0, 0, 0, 1, 9);
    chk("r9 simul fire", obs_fire, 1);
    chk("r9 simul inflight", inflight, 4);
    chk("r9 simul busy", busy_vec, 16'h0280);

    // Underflow on r12, then register-0 traffic.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    chk("underflow set", err_underflow, 1);
    cycle(1, 1, 1, 0, 1, 0, 1, 0, 1, 0);
    chk("r0 stall", obs_stall, 0);
    chk("r0 inflight", inflight, 4);
    chk("underflow sticky", err_underflow, 1);

    // Reset wins over a simultaneous issue.
    cycle(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    chk("r3 busy", busy_vec[3], 1);
    cycle(0, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    chk("rst busy", busy_vec, 16'h0000);
    chk("rst inflight", inflight, 0);
    chk("rst err", err_underflow, 0);

    // Randomized traffic over a small address window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks register-file destinations that are issued from ID and not yet written back in WB.
- Stalls ID while a source operand, or the destination slot, is still pending a write.
- Sits beside register_file and drives the writer-side bookkeeping that register_file itself does not do.
- All register addressing uses `REG_ADDR_LEN` and `REG_NUM` from defines.v.

Parameters:
- MAX_INFLIGHT, 3, maximum outstanding writes per register (1..7).
- CNT_W, 3, width of each per-register pending counter; must satisfy 2^CNT_W > MAX_INFLIGHT.
- TOT_W, 6, width of the total in-flight counter; must hold REG_NUM*MAX_INFLIGHT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- issue_valid  input  1  an instruction is presented in ID this cycle.
- issue_we  input  1  the presented instruction writes a register.
- issue_waddr  input  `REG_ADDR_LEN  destination register.
- issue_use1  input  1  the instruction reads raddr1.
- issue_raddr1  input  `REG_ADDR_LEN  first source register.
- issue_use2  input  1  the instruction reads raddr2.
- issue_raddr2  input  `REG_ADDR_LEN  second source register.
- wb_valid  input  1  register_file write this cycle (state_regfile_write && we).
- wb_waddr  input  `REG_ADDR_LEN  register being written back.
- stall  output  1  ID must hold; combinational.
- issue_fire  output  1  issue_valid && !stall.
- busy_vec  output  `REG_NUM  registered; bit r = (cnt[r] != 0).
- inflight  output  TOT_W  registered; sum of all per-register counters.
- err_underflow  output  1  sticky; set by a write-back to a non-pending register.

Behaviour:
- Reset (rst_n low at a rising edge):
  - all cnt[r] = 0, busy_vec = 0, inflight = 0, err_underflow = 0.
  - Reset wins over any simultaneous issue or write-back.
- Register 0:
  - never tracked; cnt[0] is always 0.
  - Sources at address 0 never stall.
  - Issue or write-back to address 0 changes no state and raises no error.
- Source hazard: haz1 = issue_use1 && issue_raddr1 != 0 && cnt[issue_raddr1] != 0. haz2 is defined the same way for source 2.
- Saturation hazard: sat = issue_we && issue_waddr != 0 && cnt[issue_waddr] == MAX_INFLIGHT.
- stall = issue_valid && (haz1 || haz2 || sat).
  - Computed from current-cycle counters only, with no write-back bypass; see the optional feature.
  - stall is 0 whenever issue_valid = 0.
- Per-register update each cycle:
  - inc[r] = issue_fire && issue_we && issue_waddr == r && r != 0.
  - dec[r] = wb_valid && wb_waddr == r && r != 0 && cnt[r] != 0.
  - inc and dec together: cnt unchanged.
  - inc only: cnt + 1.
  - dec only: cnt - 1.
- Underflow:
  - A wb_valid to r != 0 with cnt[r] == 0 sets err_underflow the next cycle.
  - The counter stays at 0.
  - err_underflow clears only on reset.
- inflight tracks the same net change: +1, −1 or 0 per cycle.
- Latency:
  - Counter, busy_vec and inflight updates are visible 1 cycle after the issue or write-back edge.
  - Example: an issue at edge N stalls a dependent instruction presented from cycle N+1.

Optional Feature:
- Macro: SCOREBOARD_FWD_EN.
- With the macro defined:
  - Write-back bypass: a source hazard is suppressed when wb_valid, wb_waddr equals the source register, and cnt[src] == 1.
  - Adds outputs fwd1 and fwd2 (1 bit each, combinational). Each is high when the bypass is taken for that source, so the ID mux selects wdata instead of rdata.
  - The saturation hazard is never bypassed.
- Without the macro:
  - no bypass, and fwd1/fwd2 are absent.
  - A dependent instruction stalls until the cycle after write-back.

Decomposition:
- Shared package (defines.v): `REG_ADDR_LEN`, `REG_NUM`, and new `SB_MAX_INFLIGHT` (default for MAX_INFLIGHT).
- One natural sub-module: sb_counter, a single saturating up/down CNT_W counter with inc, dec and underflow flag. It is instantiated REG_NUM−1 times in a generate loop.

Test Plan:
- Reset, then issue_valid=1, we=1, waddr=5 -> issue_fire=1; next cycle busy_vec[5]=1 and inflight=1.
- Dependent read:
  - Issue raddr1=5, use1=1 while cnt[5]=1 -> stall=1.
  - Apply wb_valid for waddr=5 -> stall drops the next cycle.
  - With SCOREBOARD_FWD_EN, stall=0 and fwd1=1 in the write-back cycle itself.
- Saturation: three issues to waddr=7 (MAX_INFLIGHT=3), then a fourth -> stall=1 and cnt[7] stays 3; one write-back -> the fourth fires.
- Simultaneous issue and write-back to register 9 with cnt=1 -> cnt stays 1 and inflight is unchanged.
- wb_valid to waddr=12 with cnt=0 -> err_underflow=1 and stays 1; an issue to waddr=0 -> no state change and stall=0.
- rst_n low with cnt[3]=2 and a simultaneous issue -> all counters 0, busy_vec=0, inflight=0 after the edge.
